// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and sizes for the BCD-to-binary converter
package bcd_pkg;

    localparam int N_DIGITS = 3;
    localparam int BIN_W    = 10;
    localparam int N_ITER   = 10;
    localparam int BCD_W    = 4 * N_DIGITS;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble digit correction (subtract 3 when >= 8)
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // A digit of 8 or more after a right shift carries a half-ten from the
    // digit above; removing 3 restores a valid BCD digit.
    assign digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential 3-digit BCD to 10-bit binary converter; optional digit check under BCD2BIN_CHECK_EN
module bcd2bin_seq
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] centaines,
    input  logic [3:0] dizaines,
    input  logic [3:0] unites,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] bin,
    output logic       out_err
);

    state_t                   state_q, state_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BCD_W-1:0]         bcd_sh;
    logic [BIN_W-1:0]         bin_sh;
    logic [BCD_W-1:0]         bcd_adj;
    logic                     accept;

    // One combined right shift: the BCD LSB falls into the binary MSB.
    assign shifted = {bcd_q, bin_q} >> 1;
    assign bcd_sh  = shifted[BCD_W+BIN_W-1:BIN_W];
    assign bin_sh  = shifted[BIN_W-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_sh[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    assign accept = in_valid && (state_q == IDLE);

`ifdef BCD2BIN_CHECK_EN
    logic err_q, err_d;
    logic digit_bad;

    assign digit_bad = (centaines > 4'd9) || (dizaines > 4'd9) || (unites > 4'd9);
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef BCD2BIN_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    bcd_d   = {centaines, dizaines, unites};
                    bin_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BCD2BIN_CHECK_EN
                    err_d   = 1'b0;
                    if (digit_bad) begin
                        // Invalid input reports straight away with a zero result.
                        bcd_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = bin_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BCD2BIN_CHECK_EN
    // Error flag register, held with the result through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign bin = bin_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed and exhaustive checks for bcd2bin_seq
module tb_bcd2bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] centaines;
    logic [3:0] dizaines;
    logic [3:0] unites;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] bin;
    logic       out_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bcd2bin_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .centaines (centaines),
        .dizaines  (dizaines),
        .unites    (unites),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // One full handshake; called at a negedge, returns at a negedge.
    task automatic run_conv(input int c, input int d, input int u, input int stall,
                            input int exp_bin, input int exp_err, input int exp_lat,
                            input string tag);
        int   lat;
        logic [9:0] b0;
        logic e0;
        logic stable;
        wait_ready(tag);
        centaines = 4'(c);
        dizaines  = 4'(d);
        unites    = 4'(u);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        centaines = 4'($urandom_range(0, 9));
        dizaines  = 4'($urandom_range(0, 9));
        unites    = 4'($urandom_range(0, 9));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_lat > 0) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        b0 = bin;
        e0 = out_err;
        stable = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            if (bin !== b0 || out_err !== e0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check_eq({tag, "_stable"}, 32'(stable), 32'd1);
        check_eq({tag, "_bin"}, 32'(bin), 32'(exp_bin));
        check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check_eq({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        centaines = 4'd0;
        dizaines  = 4'd0;
        unites    = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_bin", 32'(bin), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 255 with immediate take; out_valid 11 cycles after accept
        run_conv(2, 5, 5, 0, 255, 0, 11, "d255");
        run_conv(9, 9, 9, 0, 999, 0, 11, "d999");
        run_conv(0, 0, 0, 0, 0, 0, 11, "d000");
        run_conv(5, 1, 2, 20, 512, 0, -1, "stall512");
        run_conv(1, 2, 8, 3, 128, 0, -1, "d128");

        // Back-to-back with in_valid held high
        wait_ready("b2b");
        in_valid  = 1'b1;
        out_ready = 1'b1;
        centaines = 4'd0;
        dizaines  = 4'd0;
        unites    = 4'd0;
        t0 = cyc;
        @(negedge clk);
        centaines = 4'd9;
        dizaines  = 4'd9;
        unites    = 4'd9;
        wait_valid("b2b_0");
        check_eq("b2b_bin0", 32'(bin), 32'd0);
        @(negedge clk);
        wait_ready("b2b_1");
        t1 = cyc;
        check_eq("b2b_period", 32'(t1 - t0), 32'd12);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("b2b_1");
        check_eq("b2b_bin999", 32'(bin), 32'd999);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of SHIFT
        wait_ready("rst_mid");
        centaines = 4'd5;
        dizaines  = 4'd5;
        unites    = 4'd5;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_bin", 32'(bin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(1, 0, 0, 0, 100, 0, 11, "after_rst");

`ifdef BCD2BIN_CHECK_EN
        run_conv(1, 10, 3, 2, 0, 1, 1, "bad_digit");
        run_conv(0, 1, 0, 0, 10, 0, 11, "after_bad");
`endif

        // Exhaustive sweep with random consumer stalls
        for (int v = 0; v < 1000; v++) begin
            run_conv(v / 100, (v / 10) % 10, v % 10, int'($urandom_range(0, 3)),
                     v, 0, -1, $sformatf("exh%0d", v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
